// File: rtl/sipp_mem_pkg.sv
// rtl/sipp_mem_pkg.sv - shared sequencer state encoding and port slice helper for sipp_mem
package sipp_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } seq_state_e;

  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/sipp_mem_init_seq.sv
// rtl/sipp_mem_init_seq.sv - init sweep FSM: walks every entry once after reset or clear
module sipp_mem_init_seq
  import sipp_mem_pkg::*;
#(
  parameter int N_ELEMENTS = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_ELEMENTS - 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clear wins over sweep completion, so a late clear always buys a full new sweep
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy      = (state_q == ST_INIT);
  assign init_we   = busy;
  assign init_addr = cnt_q;

endmodule

// File: rtl/sipp_mem_multiport.sv
// rtl/sipp_mem_multiport.sv - N combinational read ports, 1 sync write port, self-initialising
// SIPP_MEM_BYPASS_EN selects write-first forwarding on read/write collisions (default read-first).
module sipp_mem_multiport
  import sipp_mem_pkg::*;
#(
  parameter int                    N_ELEMENTS = 256,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    N_RD_PORTS = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_RD_PORTS-1:0]            rd_en,
  input  logic [N_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic                             wr,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic                             clear,
  output logic                             busy
);

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  sipp_mem_init_seq #(
    .N_ELEMENTS(N_ELEMENTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  logic [DATA_WIDTH-1:0] mem_q [N_ELEMENTS];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_in_range;

  assign wr_in_range = (32'(wr_addr) < N_ELEMENTS);

  // init_we is high for the whole sweep, which is what drops user writes while busy
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = w_data;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr;
      mem_wdata = INIT_VALUE;
    end else if (wr && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar p = 0; p < N_RD_PORTS; p++) begin : g_rd
    localparam int A_LSB = slice_lsb(p, ADDR_WIDTH);
    localparam int D_LSB = slice_lsb(p, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] word;

    assign addr = rd_addr[A_LSB +: ADDR_WIDTH];

    always_comb begin
      word = '0;
      if (rd_en[p] && !busy && (32'(addr) < N_ELEMENTS)) begin
`ifdef SIPP_MEM_BYPASS_EN
        if (wr && (addr == wr_addr)) begin
          word = w_data;
        end else begin
          word = mem_q[addr];
        end
`else
        word = mem_q[addr];
`endif
      end
    end

    assign rd_data[D_LSB +: DATA_WIDTH] = word;
  end

endmodule

// File: tb/tb_sipp_mem_multiport.sv
// tb/tb_sipp_mem_multiport.sv - self-checking bench: 256- and 200-entry instances, shared stimulus
module tb_sipp_mem_multiport;

  localparam int          NA   = 256;
  localparam int          NB   = 200;
  localparam logic [15:0] INIT = 16'h00C3;
`ifdef SIPP_MEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [15:0] rd_addr;
  logic        wr;
  logic [7:0]  wr_addr;
  logic [15:0] w_data;
  logic        clear;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sipp_mem_multiport #(
    .N_ELEMENTS(NA), .ADDR_WIDTH(8), .DATA_WIDTH(16), .N_RD_PORTS(2), .INIT_VALUE(INIT)
  ) dut_a (
    .clk(clk), .rst(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr(wr), .wr_addr(wr_addr), .w_data(w_data), .clear(clear), .busy(busy_a)
  );

  sipp_mem_multiport #(
    .N_ELEMENTS(NB), .ADDR_WIDTH(8), .DATA_WIDTH(16), .N_RD_PORTS(2), .INIT_VALUE(INIT)
  ) dut_b (
    .clk(clk), .rst(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr(wr), .wr_addr(wr_addr), .w_data(w_data), .clear(clear), .busy(busy_b)
  );

  // Model: busy lasts a fixed number of edges after reset/clear; when it ends every
  // entry holds INIT. Accepted user writes land directly in the array.
  logic [15:0] ma [NA];
  logic [15:0] mb [NB];
  int          left_a, left_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_a <= NA;
      left_b <= NB;
    end else begin
      if (wr && left_a == 0 && int'(wr_addr) < NA) ma[wr_addr] <= w_data;
      if (wr && left_b == 0 && int'(wr_addr) < NB) mb[wr_addr] <= w_data;
      if (clear) left_a <= NA;
      else if (left_a > 0) begin
        left_a <= left_a - 1;
        if (left_a == 1) for (int i = 0; i < NA; i++) ma[i] <= INIT;
      end
      if (clear) left_b <= NB;
      else if (left_b > 0) begin
        left_b <= left_b - 1;
        if (left_b == 1) for (int i = 0; i < NB; i++) mb[i] <= INIT;
      end
    end
  end

  function automatic logic [15:0] exp_rd(input bit inst_b, input int p);
    int a;
    int n;
    int left;
    a    = int'(rd_addr[p*8 +: 8]);
    n    = inst_b ? NB : NA;
    left = inst_b ? left_b : left_a;
    if (!rd_en[p] || left != 0 || a >= n) return 16'h0000;
    if (BYPASS && wr && a == int'(wr_addr)) return w_data;
    return inst_b ? mb[a] : ma[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("model_a_rd%0d", p), 32'(rd_data_a[p*16 +: 16]), 32'(exp_rd(1'b0, p)));
        chk($sformatf("model_b_rd%0d", p), 32'(rd_data_b[p*16 +: 16]), 32'(exp_rd(1'b1, p)));
      end
      chk("model_a_busy", 32'(busy_a), 32'(left_a != 0));
      chk("model_b_busy", 32'(busy_b), 32'(left_b != 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  // Counts edges from now until each instance drops busy; returns 0 on timeout.
  task automatic count_sweep(output int fa, output int fb);
    int n;
    n  = 0;
    fa = 0;
    fb = 0;
    while ((fa == 0 || fb == 0) && n < 600) begin
      cyc();
      n++;
      if (!busy_a && fa == 0) fa = n;
      if (!busy_b && fb == 0) fb = n;
    end
  endtask

  int fa, fb;

  initial begin
    rst_n = 1'b1;
    wr = 1'b0; wr_addr = '0; w_data = '0; clear = 1'b0;
    set_rd(2'b11, 8'h00, 8'h00);
    #3 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    @(negedge clk);
    chk("reset_busy_a", 32'(busy_a), 32'd1);
    chk("reset_busy_b", 32'(busy_b), 32'd1);
    chk("reset_rd_a", rd_data_a, 32'd0);
    chk("reset_rd_b", rd_data_b, 32'd0);

    cyc();
    rst_n = 1'b1;
    count_sweep(fa, fb);
    chk("sweep_len_a", 32'(fa), 32'(NA));
    chk("sweep_len_b", 32'(fb), 32'(NB));

    for (int a = 0; a < 256; a++) begin
      set_rd(2'b11, 8'(a), 8'(255 - a));
      @(negedge clk);
      chk("init_read_a0", 32'(rd_data_a[15:0]), 32'(INIT));
      chk("init_read_a1", 32'(rd_data_a[31:16]), 32'(INIT));
      cyc();
    end

    wr = 1'b1; wr_addr = 8'h10; w_data = 16'h1234;
    cyc();
    wr_addr = 8'h20; w_data = 16'hBEEF;
    cyc();
    wr = 1'b0;
    set_rd(2'b11, 8'h10, 8'h20);
    @(negedge clk);
    chk("dual_read_p0", 32'(rd_data_a[15:0]), 32'h1234);
    chk("dual_read_p1", 32'(rd_data_a[31:16]), 32'hBEEF);
    cyc();

    set_rd(2'b01, 8'h10, 8'h20);
    @(negedge clk);
    chk("rd_en_off_a", 32'(rd_data_a[31:16]), 32'h0);
    chk("rd_en_off_b", 32'(rd_data_b[31:16]), 32'h0);
    chk("rd_en_on_b", 32'(rd_data_b[15:0]), 32'h1234);
    cyc();

    wr = 1'b1; wr_addr = 8'h05; w_data = 16'hA5A5;
    set_rd(2'b11, 8'h05, 8'h05);
    @(negedge clk);
    chk("collide_p0", 32'(rd_data_a[15:0]), BYPASS ? 32'hA5A5 : 32'(INIT));
    chk("collide_p1", 32'(rd_data_a[31:16]), BYPASS ? 32'hA5A5 : 32'(INIT));
    cyc();
    wr = 1'b0;
    @(negedge clk);
    chk("collide_next", 32'(rd_data_a[15:0]), 32'hA5A5);
    cyc();

    wr = 1'b1; wr_addr = 8'd250; w_data = 16'h4444;
    set_rd(2'b11, 8'd250, 8'd199);
    @(negedge clk);
    chk("range_b_rd250", 32'(rd_data_b[15:0]), 32'h0);
    chk("range_b_rd199", 32'(rd_data_b[31:16]), 32'(INIT));
    cyc();
    wr = 1'b0;
    set_rd(2'b11, 8'd250, 8'd200);
    @(negedge clk);
    chk("range_a_wr250", 32'(rd_data_a[15:0]), 32'h4444);
    chk("range_b_wr250", 32'(rd_data_b[15:0]), 32'h0);
    chk("range_b_rd200", 32'(rd_data_b[31:16]), 32'h0);
    cyc();

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    wr = 1'b1; wr_addr = 8'h03; w_data = 16'h7777;
    cyc();
    wr = 1'b0;
    count_sweep(fa, fb);
    chk("clear_done_a", 32'(fa != 0), 32'd1);
    chk("clear_done_b", 32'(fb != 0), 32'd1);
    set_rd(2'b11, 8'h03, 8'h10);
    @(negedge clk);
    chk("busy_drop_a", 32'(rd_data_a[15:0]), 32'(INIT));
    chk("busy_drop_b", 32'(rd_data_b[15:0]), 32'(INIT));
    chk("clear_wipe_a", 32'(rd_data_a[31:16]), 32'(INIT));
    cyc();

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midsweep_rst_busy", 32'(busy_a), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    count_sweep(fa, fb);
    chk("midsweep_len_a", 32'(fa), 32'(NA));
    chk("midsweep_len_b", 32'(fb), 32'(NB));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
